adder_share_arbiter: RTL and testbench

Shares one pipelined WIDTH-bit adder datapath between NREQ requesters. The adder is the registered-in/registered-out ripple-carry adder timing wrapper. The block round-robin arbitrates valid/ready requests and issues at most one operation per cycle to the adder. It tags each issued operation and routes the returned sum/cout to the originating requester. It sits between client blocks and the adder instance at the same hierarchy level.

---
 rtl/adder_share_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/adder_share_arbiter.sv | 147 ++++++++++++++
 tb/tb_adder_share_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// Shared constants and tag types for the adder-sharing arbiter.
// Tag ids are sized for the largest supported requester count (16).
package adder_share_pkg;

  localparam int unsigned DefNreq  = 4;
  localparam int unsigned DefWidth = 64;
  localparam int unsigned DefLat   = 2;
  localparam int unsigned IdMaxW   = 4;

  function automatic int unsigned tag_w(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  typedef struct packed {
    logic              valid;
    logic [IdMaxW-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping modulo NREQ.
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  localparam int unsigned IdW = tag_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IdW-1:0]  id
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx[IdW-1:0]]) begin
        grant[idx[IdW-1:0]] = 1'b1;
        id                  = idx[IdW-1:0];
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one pipelined adder among NREQ requesters: round-robin issue, tag pipe aligned to the
// adder latency, and one-hot routing of each result back to its requester.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int unsigned NREQ  = DefNreq,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned LAT   = DefLat
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*WIDTH-1:0]      req_a,
  input  logic [NREQ*WIDTH-1:0]      req_b,
  input  logic [NREQ-1:0]            req_cin,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  output logic                       add_cin,
  output logic                       add_issue,
  input  logic [WIDTH-1:0]           add_sum,
  input  logic                       add_cout,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_cout,
  output logic [$clog2(LAT+3)-1:0]   inflight
);

  localparam int unsigned IdW  = tag_w(NREQ);
  localparam int unsigned CntW = $clog2(LAT + 3);

  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d, grant_id, issue_id_q;
  logic [NREQ-1:0]  grant;
  logic             accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_cin;
  logic [WIDTH-1:0] add_a_q, add_b_q;
  logic             add_cin_q, add_issue_q;
  tag_t             tag_q [LAT];
  tag_t             tag_out;
  logic [NREQ-1:0]  rsp_valid_d, rsp_valid_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_cout_q;
  logic [CntW-1:0]  inflight_d, inflight_q;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .req  (req_valid),
    .ptr  (rr_ptr_q),
    .grant(grant),
    .id   (grant_id)
  );

  // Reset masks the grant so nothing is accepted while rst is high.
  assign req_ready = rst ? '0 : grant;
  assign accept    = |req_ready;
  assign rr_ptr_d  = (32'(grant_id) == NREQ - 1) ? '0 : grant_id + IdW'(1);

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_cin = req_cin[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      add_issue_q <= 1'b0;
      issue_id_q  <= '0;
    end else begin
      add_issue_q <= accept;
      if (accept) begin
        rr_ptr_q   <= rr_ptr_d;
        add_a_q    <= sel_a;
        add_b_q    <= sel_b;
        add_cin_q  <= sel_cin;
        issue_id_q <= grant_id;
      end
    end
  end

  // Last stage lines up with add_sum for the operation issued LAT cycles earlier.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= '{valid: add_issue_q, id: IdMaxW'(issue_id_q)};
      for (int unsigned s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign tag_out = tag_q[LAT-1];

  always_comb begin
    rsp_valid_d = '0;
    if (tag_out.valid) rsp_valid_d[tag_out.id[IdW-1:0]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (tag_out.valid) begin
        rsp_sum_q  <= add_sum;
        rsp_cout_q <= add_cout;
      end
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, |rsp_valid_q})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) inflight_q <= '0;
    else     inflight_q <= inflight_d;
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign add_issue = add_issue_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign inflight  = inflight_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed and random bench for adder_share_arbiter with a LAT=2 registered adder partner and
// a transaction-level reference model (expected responses kept in a queue).
module tb_adder_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 64;
  localparam int LAT   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_ready, req_cin, rsp_valid;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0]      add_a, add_b, add_sum, rsp_sum;
  logic                  add_cin, add_issue, add_cout, rsp_cout;
  logic [2:0]            inflight;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .LAT  (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_cin  (req_cin),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_issue(add_issue),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .rsp_valid(rsp_valid),
    .rsp_sum  (rsp_sum),
    .rsp_cout (rsp_cout),
    .inflight (inflight)
  );

  // Adder partner: registered inputs, registered outputs (two cycles from add_issue).
  logic [WIDTH-1:0] ad_a_q = '0, ad_b_q = '0;
  logic             ad_cin_q = 1'b0;
  initial {add_cout, add_sum} = '0;
  always @(posedge clk) begin
    ad_a_q   <= add_a;
    ad_b_q   <= add_b;
    ad_cin_q <= add_cin;
    {add_cout, add_sum} <= {1'b0, ad_a_q} + {1'b0, ad_b_q} + 65'(ad_cin_q);
  end

  // Reference model state
  typedef struct {
    int          id;
    logic [63:0] sum;
    logic        cout;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          ptr_m = 0;
  int          prob = 0;
  bit          issue_m = 0;
  logic [63:0] last_a = '0, last_b = '0, last_sum = '0;
  logic        last_cin = 1'b0, last_cout = 1'b0;
  logic [3:0]  pend = '0;
  logic [63:0] ma[NREQ], mb[NREQ];
  logic        mcin[NREQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    v = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) v = '1;
    return v;
  endfunction

  task automatic post(input int i, input logic [63:0] a, input logic [63:0] b, input logic c);
    ma[i]   = a;
    mb[i]   = b;
    mcin[i] = c;
    pend[i] = 1'b1;
  endtask

  // One clock cycle: drive, check at negedge, advance the model at posedge.
  task automatic cycle(input bit r);
    int          g;
    int          infl;
    logic [3:0]  erv;
    logic [64:0] s;
    for (int i = 0; i < NREQ; i++)
      if (!pend[i] && $urandom_range(0, 99) < prob)
        post(i, rnd64(), rnd64(), 1'($urandom_range(0, 1)));
    rst = r;
    req_valid = pend;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = ma[i];
      req_b[i*WIDTH +: WIDTH] = mb[i];
      req_cin[i]              = mcin[i];
    end
    @(negedge clk);
    g = -1;
    if (!r)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && pend[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
    erv  = '0;
    infl = 0;
    foreach (q[j]) begin
      if (q[j].acc + 2 + LAT == cyc) begin
        erv       = 4'(1 << q[j].id);
        last_sum  = q[j].sum;
        last_cout = q[j].cout;
      end
      if (q[j].acc < cyc && q[j].acc + 2 + LAT >= cyc) infl++;
    end
    chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
    chk("add_issue", 64'(add_issue), 64'(issue_m));
    chk("add_a", add_a, last_a);
    chk("add_b", add_b, last_b);
    chk("add_cin", 64'(add_cin), 64'(last_cin));
    chk("rsp_valid", 64'(rsp_valid), 64'(erv));
    chk("rsp_sum", rsp_sum, last_sum);
    chk("rsp_cout", 64'(rsp_cout), 64'(last_cout));
    chk("inflight", 64'(inflight), 64'(infl));
    @(posedge clk);
    if (r) begin
      q.delete();
      ptr_m   = 0;
      issue_m = 0;
      {last_a, last_b, last_cin, last_sum, last_cout} = '0;
    end else if (g >= 0) begin
      s = {1'b0, ma[g]} + {1'b0, mb[g]} + 65'(mcin[g]);
      q.push_back('{g, s[63:0], s[64], cyc});
      last_a   = ma[g];
      last_b   = mb[g];
      last_cin = mcin[g];
      issue_m  = 1;
      ptr_m    = (g + 1) % NREQ;
      pend[g]  = 1'b0;
    end else begin
      issue_m = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      ma[i]   = '0;
      mb[i]   = '0;
      mcin[i] = 1'b0;
    end
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    @(posedge clk);
    #1;
    cycle(1'b1);
    cycle(1'b1);

    // Single op with overflow into cout
    post(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    run(6);
    // Carry-in
    post(0, 64'd5, 64'd7, 1'b1);
    run(6);
    // Hold: nothing valid, issue registers must keep last operands
    run(3);

    // Full contention from reset
    cycle(1'b1);
    prob = 100;
    run(20);
    prob = 0;
    run(6);

    // Rotation: last grant to 1, then 1 and 3 compete
    cycle(1'b1);
    post(1, 64'd10, 64'd20, 1'b0);
    run(1);
    post(1, 64'd11, 64'd21, 1'b0);
    post(3, 64'd30, 64'd40, 1'b1);
    run(1);
    post(3, 64'd31, 64'd41, 1'b0);
    run(8);

    // Reset mid-flight: accepted op must never respond
    post(1, 64'd100, 64'd200, 1'b0);
    run(1);
    cycle(1'b1);
    cycle(1'b1);
    run(6);
    post(2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    run(6);

    // Random traffic with occasional resets
    prob = 40;
    for (int i = 0; i < 400; i++) cycle($urandom_range(0, 59) == 0);
    prob = 0;
    run(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
